// File: rtl/mau_pkg.sv
// Shared encodings and lane helpers for the memory access unit.
package mau_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LD_ADDR,
    ST_LD_DATA,
    ST_ST_WORD,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_RESP
  } mau_state_e;

  localparam logic [31:0] LANE_MASK_BYTE = 32'h0000_00FF;
  localparam logic [31:0] LANE_MASK_HALF = 32'h0000_FFFF;
  localparam logic [31:0] LANE_MASK_WORD = 32'hFFFF_FFFF;

  // Big-endian: byte offset 0 lives in bits [31:24], so shift = (3 - off) * 8.
  function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return {~off, 3'b000};
      SIZE_HALF: return {~off[1], 4'b0000};
      default:   return 5'd0;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return LANE_MASK_BYTE;
      SIZE_HALF: return LANE_MASK_HALF;
      default:   return LANE_MASK_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational lane logic: load extraction/extension and sub-word store merge.
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] word_in,
  input  logic [31:0] wdata,
  output logic [31:0] load_out,
  output logic [31:0] merged_word
);

  logic [4:0]  shift;
  logic [31:0] mask;
  logic [31:0] lane;

  always_comb begin
    shift = lane_shift(size, addr_lo);
    mask  = lane_mask(size);
    lane  = (word_in >> shift) & mask;

    load_out = lane;
    if (sign_ext) begin
      case (size)
        SIZE_BYTE: load_out = {{24{lane[7]}}, lane[7:0]};
        SIZE_HALF: load_out = {{16{lane[15]}}, lane[15:0]};
        default:   load_out = lane;
      endcase
    end

    merged_word = (word_in & ~(mask << shift)) | ((wdata & mask) << shift);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator translating byte-addressed CPU requests into RAM word cycles.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned ADDR_W    = 30,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_address,
  output logic [31:0]       ram_data,
  input  logic [31:0]       ram_q
);

  mau_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req_err;
  logic [31:0] load_out;
  logic [31:0] merged_word;

  mau_lane_align u_lane_align (
    .size        (size_q),
    .addr_lo     (addr_q[1:0]),
    .sign_ext    (signed_q),
    .word_in     (ram_q),
    .wdata       (wdata_q),
    .load_out    (load_out),
    .merged_word (merged_word)
  );

  always_comb begin
    req_err = 1'b0;
    if (req_size == SIZE_RSVD)                                req_err = 1'b1;
    if (req_size == SIZE_HALF && req_addr[0])                 req_err = 1'b1;
    if (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)      req_err = 1'b1;
    if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS))            req_err = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          err_d    = req_err;
          if (req_err)                  state_d = ST_RESP;
          else if (!req_we)             state_d = ST_LD_ADDR;
          else if (req_size == SIZE_WORD) state_d = ST_ST_WORD;
          else                          state_d = ST_RMW_RD;
        end
      end
      ST_LD_ADDR: state_d = ST_LD_DATA;
      ST_LD_DATA: begin
        rdata_d = load_out;
        state_d = ST_RESP;
      end
      ST_ST_WORD: state_d = ST_RESP;
      ST_RMW_RD:  state_d = ST_RMW_WR;
      ST_RMW_WR:  state_d = ST_RESP;
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state_q == ST_IDLE);
    resp_valid  = (state_q == ST_RESP);
    resp_rdata  = rdata_q;
    resp_err    = err_q;
    ram_address = ADDR_W'(addr_q[31:2]);
    ram_wren    = 1'b0;
    ram_data    = '0;
    case (state_q)
      ST_ST_WORD: begin
        ram_wren = 1'b1;
        ram_data = wdata_q;
      end
      ST_RMW_WR: begin
        ram_wren = 1'b1;
        ram_data = merged_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      size_q   <= '0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

endmodule
